// File: rtl/rocketcpu_codec_spi_rx.sv
// Codec-control SPI receiver: synchronized SPI frames update 9-bit shadow registers read over Wishbone.
// Optional word interrupt: define CODEC_SPI_RX_IRQ_EN.
module rocketcpu_codec_spi_rx #(
  parameter int NREGS = 16
) (
  input  logic        i_wb_clk,
  input  logic        reset_n,
  input  logic        codec_clk,
  input  logic        codec_cs,
  input  logic        codec_di,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_word_valid,
  output logic        o_irq
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [6:0] ADDR_RST = 7'h0F;
  localparam logic [4:0] OFF_STAT = 5'h10;

  logic [2:0]  sclk_q;
  logic [2:0]  scs_q;
  logic [1:0]  sdi_q;
  logic [1:0]  warm_q;
  logic        armed_q;
  logic        frame_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d;
  logic [8:0]  regs_q [NREGS];
  logic        err_len_q, err_addr_q;
  logic [7:0]  wc_q;
  logic        ack_q;
  logic [31:0] rdt_q, rdt_d;
  logic        valid_q;

  logic clk_rise, cs_fall, cs_rise, frame_end;
  logic len_ok, is_rst, is_wr, accept;
  logic bad_len, bad_addr;
  logic [6:0] waddr;

  // bit [2] of each sync chain is the previous synchronized value
  assign clk_rise  = sclk_q[1] & ~sclk_q[2];
  assign cs_fall   = ~scs_q[1] & scs_q[2];
  assign cs_rise   = scs_q[1] & ~scs_q[2];
  assign frame_end = cs_rise & frame_q;

  assign waddr    = sh_q[15:9];
  assign len_ok   = (cnt_q == 5'd16);
  assign is_rst   = len_ok & (waddr == ADDR_RST);
  assign is_wr    = len_ok & ~is_rst & (waddr < 7'(NREGS));
  assign accept   = frame_end & (is_rst | is_wr);
  assign bad_len  = frame_end & ~len_ok;
  assign bad_addr = frame_end & len_ok & ~is_rst & ~is_wr;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (cs_fall && armed_q) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (frame_q && clk_rise && !scs_q[1]) begin
      sh_d  = {sh_q[14:0], sdi_q[1]};
      cnt_d = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
    end
  end

  logic       bus_req, stat_rd, stat_wr;
  logic [4:0] off;
  logic [1:0] w1c;

  assign bus_req = i_wb_cyc & ~ack_q;
  assign off     = i_wb_adr[6:2];
  assign stat_rd = bus_req & ~i_wb_we & (off == OFF_STAT);
  assign stat_wr = bus_req & i_wb_we & (off == OFF_STAT);
  assign w1c     = stat_wr ? i_wb_dat[1:0] : 2'b00;

  always_comb begin
    rdt_d = '0;
    if (off < 5'(NREGS))
      rdt_d = {23'b0, regs_q[off[AW-1:0]]};
    else if (off == OFF_STAT)
      rdt_d = {16'b0, wc_q, 6'b0, err_addr_q, err_len_q};
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q  <= 3'b000;
      scs_q   <= 3'b111;
      sdi_q   <= 2'b00;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
      frame_q <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], codec_clk};
      scs_q   <= {scs_q[1:0], codec_cs};
      sdi_q   <= {sdi_q[0], codec_di};
      warm_q  <= {warm_q[0], 1'b1};
      // a frame already running at reset release is never started
      armed_q <= armed_q | (warm_q[1] & scs_q[1]);
      if (cs_fall && armed_q)
        frame_q <= 1'b1;
      else if (cs_rise)
        frame_q <= 1'b0;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      err_len_q  <= 1'b0;
      err_addr_q <= 1'b0;
      wc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (is_rst) begin
          for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
        end else begin
          regs_q[sh_q[9 +: AW]] <= sh_q[8:0];
        end
      end
      err_len_q  <= (err_len_q & ~w1c[0]) | bad_len;
      err_addr_q <= (err_addr_q & ~w1c[1]) | bad_addr;
      if (accept)
        wc_q <= wc_q + 8'd1;
      valid_q <= accept;
    end
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= bus_req;
      rdt_q <= bus_req ? rdt_d : 32'b0;
    end
  end

  assign o_wb_ack     = ack_q;
  assign o_wb_rdt     = rdt_q;
  assign o_word_valid = valid_q;

`ifdef CODEC_SPI_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n)
      irq_q <= 1'b0;
    else if (accept)
      irq_q <= 1'b1;
    else if (stat_rd)
      irq_q <= 1'b0;
  end
  assign o_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = stat_rd;
  assign o_irq = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{i_wb_adr[31:7], i_wb_adr[1:0], i_wb_dat[31:2]};

endmodule

// File: tb/tb_rocketcpu_codec_spi_rx.sv
// Bench for rocketcpu_codec_spi_rx: directed + random SPI frames vs a word-level model.
// Build with or without CODEC_SPI_RX_IRQ_EN.
module tb_rocketcpu_codec_spi_rx;
  localparam int NREGS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        scs = 1'b1;
  logic        sdi = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic        wvalid;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int npulse = 0;

  logic [8:0] mregs [NREGS];
  int         m_wc;
  logic       m_el, m_ea, m_irq;
  int         m_pulse;

  rocketcpu_codec_spi_rx #(.NREGS(NREGS)) dut (
    .i_wb_clk    (clk),
    .reset_n     (rst_n),
    .codec_clk   (sclk),
    .codec_cs    (scs),
    .codec_di    (sdi),
    .i_wb_adr    (adr),
    .i_wb_cyc    (cyc),
    .i_wb_we     (we),
    .i_wb_dat    (wdat),
    .o_wb_rdt    (rdt),
    .o_wb_ack    (ack),
    .o_word_valid(wvalid),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wvalid) npulse++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (mregs[i]) mregs[i] = '0;
    m_wc = 0; m_el = 0; m_ea = 0; m_irq = 0;
  endtask

  task automatic model_frame(input logic [31:0] w, input int nb);
    int a;
    if (nb != 16) begin
      m_el = 1'b1;
    end else begin
      a = int'(w[15:9]);
      if (a == 15 || a < NREGS) begin
        if (a == 15) foreach (mregs[i]) mregs[i] = '0;
        else mregs[a] = w[8:0];
        m_wc = (m_wc + 1) % 256;
        m_pulse++;
`ifdef CODEC_SPI_RX_IRQ_EN
        m_irq = 1'b1;
`endif
      end else begin
        m_ea = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] wc8;
    wc8 = m_wc[7:0];
    return {16'b0, wc8, 6'b0, m_ea, m_el};
  endfunction

  task automatic send_bit(input logic b);
    sdi = b;
    #20 sclk = 1'b1;
    #20 sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input int nb);
    scs = 1'b0;
    #40;
    for (int i = nb - 1; i >= 0; i--) send_bit(w[i]);
    #20;
    @(posedge clk); #1;
    scs = 1'b1;
    model_frame(w, nb);
  endtask

  task automatic do_frame(input logic [31:0] w, input int nb);
    send_frame(w, nb);
    wait_cycles(6);
  endtask

  task automatic wb_xfer(input logic [4:0] off, input logic wr,
                         input logic [31:0] d, output logic [31:0] q);
    int n;
    adr = {25'b0, off, 2'b00};
    we = wr; wdat = d; cyc = 1'b1; n = 0;
    @(posedge clk); #1;
    while (!ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_latency", n, 0);
    q = rdt;
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {31'b0, ack}, 32'b0);
  endtask

  task automatic check_reg(input int a, input string tag);
    logic [31:0] q;
    wb_xfer(a[4:0], 1'b0, 32'b0, q);
    check(tag, q, {23'b0, mregs[a]});
  endtask

  task automatic check_status(input string tag);
    logic [31:0] q, e;
    e = m_status();
    wb_xfer(5'd16, 1'b0, 32'b0, q);
    m_irq = 1'b0;
    check(tag, q, e);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREGS; i++) check_reg(i, tag);
  endtask

  initial begin
    logic [31:0] q, w;
    int a, nb;
    model_reset();
    m_pulse = 0;
    wait_cycles(3);
    check("rst_ack", {31'b0, ack}, 32'b0);
    check("rst_rdt", rdt, 32'b0);
    check("rst_valid", {31'b0, wvalid}, 32'b0);
    check("rst_irq", {31'b0, irq}, 32'b0);
    rst_n = 1'b1;
    wait_cycles(5);
    check_status("rst_status");
    check_reg(7, "rst_reg7");

    // 0x0E4A -> reg7 = 0x04A, exact 3-edge latency
    send_frame(32'h0E4A, 16);
    wait_cycles(2);
    check("lat_e2", {31'b0, wvalid}, 32'b0);
    wait_cycles(1);
    check("lat_e3", {31'b0, wvalid}, 32'b1);
    wait_cycles(1);
    check("lat_e4", {31'b0, wvalid}, 32'b0);
    wait_cycles(3);
    check("pulse_0e4a", npulse, m_pulse);
    check("irq_set", {31'b0, irq}, {31'b0, m_irq});
    check_reg(7, "reg7_04a");
    check_status("status_100");
    check("irq_clr", {31'b0, irq}, {31'b0, m_irq});

    // short frame -> err_len, then W1C
    do_frame(32'h1234, 15);
    check_status("errlen");
    check_all("regs_after_short");
    wb_xfer(5'd16, 1'b1, 32'h1, q);
    m_el = 1'b0;
    check_status("errlen_w1c");

    // codec reset word clears everything
    do_frame(32'h07FF, 16);
    check_reg(3, "reg3_1ff");
    do_frame(32'h1E00, 16);
    check("pulse_rst", npulse, m_pulse);
    check_all("regs_cleared");

    // out-of-range address
    do_frame(32'h2400, 16);
    check("pulse_badaddr", npulse, m_pulse);
    check_status("erraddr");
    wb_xfer(5'd16, 1'b1, 32'h3, q);
    m_el = 1'b0; m_ea = 1'b0;

    // unmapped reads and ignored writes
    wb_xfer(5'd20, 1'b0, 32'b0, q);
    check("rd_off20", q, 32'b0);
    wb_xfer(5'd3, 1'b1, 32'h1FF, q);
    check_reg(3, "wr_ignored");

    // random frames
    for (int k = 0; k < 30; k++) begin
      a = $urandom_range(0, 20);
      w = {16'b0, 7'(a), 9'($urandom)};
      nb = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? 17 : 15) : 16;
      if (nb == 17) w[16] = 1'($urandom);
      do_frame(w, nb);
      check("rnd_pulse", npulse, m_pulse);
      check_reg($urandom_range(0, NREGS - 1), "rnd_reg");
      check_status("rnd_status");
      if ($urandom_range(0, 3) == 0) begin
        wb_xfer(5'd16, 1'b1, 32'h3, q);
        m_el = 1'b0; m_ea = 1'b0;
      end
    end
    check_all("rnd_regs");

    // reset in the middle of a frame
    scs = 1'b0;
    #40;
    for (int i = 15; i >= 8; i--) send_bit(w[i]);
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    model_reset();
    w = 32'h0C55;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    #20;
    @(posedge clk); #1;
    scs = 1'b1;
    wait_cycles(6);
    check("pulse_midrst", npulse, m_pulse);
    check_status("status_midrst");
    check_all("regs_midrst");
    do_frame(32'h0A05, 16);
    check_reg(5, "reg5_005");

    // word counter wrap
    while (m_wc != 255) do_frame({16'b0, 7'($urandom_range(0, 13)), 9'($urandom)}, 16);
    check_status("wc_255");
    do_frame(32'h0201, 16);
    check_status("wc_wrap");
    check("pulse_total", npulse, m_pulse);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
